// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one memory bus between the icache fetch path and the dcache path.
//   A round-robin choice between the two requesters is made combinationally
//   each cycle and driven onto proc2mem_*. Each accepted load records its tag
//   owner so that returned data can be routed back to the right cache.
//
// Ports
//   clock, reset           system clock, synchronous active-low reset
//   icache_command/addr    icache request (only BUS_LOAD is acted on)
//   dcache_command/addr/data  dcache request (load or store)
//   icache_gnt/dcache_gnt  request accepted this cycle
//   gnt_tag                accept tag of this cycle (mem2proc_response)
//   proc2mem_*             bus command/address/store data
//   mem2proc_response      accept tag from memory, 0 = reject
//   mem2proc_data/tag      returned load data and its tag, tag 0 = none
//   icache/dcache_rsp_valid  returned data belongs to that cache
//   rsp_tag/rsp_data       tag and data of the returned load
//   outstanding            number of loads in flight
//   spurious_tag           sticky: data returned for a tag nobody owns
//   gnt_debug              {dcache_sel, icache_sel} this cycle
module mem_bus_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned TAG_W           = 4,
    parameter int unsigned XLEN            = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       icache_command,
    input  logic [XLEN-1:0]  icache_addr,
    input  logic [1:0]       dcache_command,
    input  logic [XLEN-1:0]  dcache_addr,
    input  logic [63:0]      dcache_data,
    output logic             icache_gnt,
    output logic             dcache_gnt,
    output logic [TAG_W-1:0] gnt_tag,
    output logic [1:0]       proc2mem_command,
    output logic [XLEN-1:0]  proc2mem_addr,
    output logic [63:0]      proc2mem_data,
    input  logic [TAG_W-1:0] mem2proc_response,
    input  logic [63:0]      mem2proc_data,
    input  logic [TAG_W-1:0] mem2proc_tag,
    output logic             icache_rsp_valid,
    output logic             dcache_rsp_valid,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [63:0]      rsp_data,
    output logic [3:0]       outstanding,
    output logic             spurious_tag,
    output logic [1:0]       gnt_debug
);

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam int unsigned NUM_TAGS = 1 << TAG_W;

    typedef enum logic {
        OWN_ICACHE = 1'b0,
        OWN_DCACHE = 1'b1
    } owner_t;

    logic [NUM_TAGS-1:0] tag_valid;
    owner_t              tag_owner [NUM_TAGS];
    owner_t              last_winner;
    logic [3:0]          count;
    logic                spurious;

    logic full, ic_cand, dc_cand, ic_sel, dc_sel;
    logic accept, acc_load, ret_hit, ret_spurious;
    owner_t ret_owner;

    always_comb begin
        full    = (count == 4'(MAX_OUTSTANDING));
        // An icache store is not a real request and is ignored.
        ic_cand = (icache_command == BUS_LOAD) && !full;
        dc_cand = ((dcache_command == BUS_LOAD) && !full) ||
                  (dcache_command == BUS_STORE);

        // On contention the requester that did not win last is chosen.
        ic_sel = ic_cand && (!dc_cand || (last_winner == OWN_DCACHE));
        dc_sel = dc_cand && !ic_sel;

        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (ic_sel) begin
            proc2mem_command = BUS_LOAD;
            proc2mem_addr    = icache_addr;
        end else if (dc_sel) begin
            proc2mem_command = dcache_command;
            proc2mem_addr    = dcache_addr;
            proc2mem_data    = dcache_data;
        end

        accept   = (ic_sel || dc_sel) && (mem2proc_response != '0);
        acc_load = accept && (proc2mem_command == BUS_LOAD);

        ret_hit      = (mem2proc_tag != '0) && tag_valid[mem2proc_tag];
        ret_spurious = (mem2proc_tag != '0) && !tag_valid[mem2proc_tag];
        ret_owner    = tag_owner[mem2proc_tag];
    end

    assign icache_gnt       = ic_sel && accept;
    assign dcache_gnt       = dc_sel && accept;
    assign gnt_tag          = mem2proc_response;
    assign gnt_debug        = {dc_sel, ic_sel};
    assign icache_rsp_valid = ret_hit && (ret_owner == OWN_ICACHE);
    assign dcache_rsp_valid = ret_hit && (ret_owner == OWN_DCACHE);
    assign rsp_tag          = mem2proc_tag;
    assign rsp_data         = mem2proc_data;
    assign outstanding      = count;
    assign spurious_tag     = spurious;

    always_ff @(posedge clock) begin
        if (!reset) begin
            tag_valid   <= '0;
            count       <= '0;
            last_winner <= OWN_DCACHE;
            spurious    <= 1'b0;
        end else begin
            // Return clears first so a same-tag allocation in this cycle wins.
            if (ret_hit)
                tag_valid[mem2proc_tag] <= 1'b0;
            if (acc_load) begin
                tag_valid[mem2proc_response] <= 1'b1;
                tag_owner[mem2proc_response] <= dc_sel ? OWN_DCACHE : OWN_ICACHE;
            end
            if (accept)
                last_winner <= dc_sel ? OWN_DCACHE : OWN_ICACHE;
            if (ret_spurious)
                spurious <= 1'b1;
            unique case ({acc_load, ret_hit})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter (instantiated with MAX_OUTSTANDING=2): a table of
// hand-derived vectors, a reset-while-busy sequence, and randomized traffic
// checked against a tag-ownership model held in an associative array.
module tb_mem_bus_arbiter;

    localparam int MAXO = 2;
    localparam logic [1:0] N = 2'd0, L = 2'd1, S = 2'd2;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  icache_command, dcache_command;
    logic [31:0] icache_addr, dcache_addr;
    logic [63:0] dcache_data;
    logic        icache_gnt, dcache_gnt;
    logic [3:0]  gnt_tag;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_response, mem2proc_tag;
    logic [63:0] mem2proc_data;
    logic        icache_rsp_valid, dcache_rsp_valid;
    logic [3:0]  rsp_tag;
    logic [63:0] rsp_data;
    logic [3:0]  outstanding;
    logic        spurious_tag;
    logic [1:0]  gnt_debug;

    mem_bus_arbiter #(.MAX_OUTSTANDING(MAXO), .TAG_W(4), .XLEN(32)) dut (
        .clock(clock), .reset(reset),
        .icache_command(icache_command), .icache_addr(icache_addr),
        .dcache_command(dcache_command), .dcache_addr(dcache_addr),
        .dcache_data(dcache_data),
        .icache_gnt(icache_gnt), .dcache_gnt(dcache_gnt), .gnt_tag(gnt_tag),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data),
        .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
        .mem2proc_tag(mem2proc_tag),
        .icache_rsp_valid(icache_rsp_valid), .dcache_rsp_valid(dcache_rsp_valid),
        .rsp_tag(rsp_tag), .rsp_data(rsp_data), .outstanding(outstanding),
        .spurious_tag(spurious_tag), .gnt_debug(gnt_debug)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  ic_cmd;
        logic [31:0] ic_addr;
        logic [1:0]  dc_cmd;
        logic [31:0] dc_addr;
        logic [63:0] dc_data;
        logic [3:0]  resp;
        logic [3:0]  rtag;
        logic [63:0] rdata;
        logic [1:0]  e_cmd;
        logic [31:0] e_addr;
        logic [63:0] e_data;
        logic        e_ignt, e_dgnt, e_irsp, e_drsp;
        logic [3:0]  e_out;
        logic        e_spur;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Reference state: key = tag in flight, value = owner (0 icache, 1 dcache).
    int owner_map [int];
    int last_w;        // 0 icache, 1 dcache
    bit spur_m;
    bit m_acc_ic, m_acc_dc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner_map.delete();
        last_w = 1;
        spur_m = 0;
    endtask

    task automatic run_cycle(input vec_t v, input bit use_table);
        bit full, ic_c, dc_c, sel_ic, sel_dc, acc, hit;
        int own;
        logic [1:0]  m_cmd;
        logic [31:0] m_addr;
        logic [63:0] m_data;
        icache_command    = v.ic_cmd;  icache_addr = v.ic_addr;
        dcache_command    = v.dc_cmd;  dcache_addr = v.dc_addr;
        dcache_data       = v.dc_data;
        mem2proc_response = v.resp;
        mem2proc_tag      = v.rtag;    mem2proc_data = v.rdata;
        @(negedge clock);
        full = owner_map.num() >= MAXO;
        ic_c = (v.ic_cmd == L) && !full;
        dc_c = ((v.dc_cmd == L) && !full) || (v.dc_cmd == S);
        if (ic_c && dc_c) sel_dc = (last_w == 0);
        else              sel_dc = dc_c;
        sel_ic = ic_c && !sel_dc;
        m_cmd  = sel_ic ? L : (sel_dc ? v.dc_cmd : N);
        m_addr = sel_ic ? v.ic_addr : (sel_dc ? v.dc_addr : 32'h0);
        m_data = sel_dc ? v.dc_data : 64'h0;
        acc    = (sel_ic || sel_dc) && (v.resp != 0);
        hit    = (v.rtag != 0) && owner_map.exists(int'(v.rtag));
        own    = hit ? owner_map[int'(v.rtag)] : 0;
        chk("gnt_tag", 64'(gnt_tag), 64'(v.resp));
        if (use_table) begin
            chk("t_cmd",  64'(proc2mem_command), 64'(v.e_cmd));
            chk("t_addr", 64'(proc2mem_addr),    64'(v.e_addr));
            chk("t_data", proc2mem_data,         v.e_data);
            chk("t_ignt", 64'(icache_gnt),       64'(v.e_ignt));
            chk("t_dgnt", 64'(dcache_gnt),       64'(v.e_dgnt));
            chk("t_irsp", 64'(icache_rsp_valid), 64'(v.e_irsp));
            chk("t_drsp", 64'(dcache_rsp_valid), 64'(v.e_drsp));
            chk("t_out",  64'(outstanding),      64'(v.e_out));
            chk("t_spur", 64'(spurious_tag),     64'(v.e_spur));
            if (v.e_irsp || v.e_drsp) begin
                chk("t_rsp_tag",  64'(rsp_tag), 64'(v.rtag));
                chk("t_rsp_data", rsp_data,     v.rdata);
            end
        end else begin
            chk("m_cmd",   64'(proc2mem_command), 64'(m_cmd));
            chk("m_addr",  64'(proc2mem_addr),    64'(m_addr));
            chk("m_data",  proc2mem_data,         m_data);
            chk("m_ignt",  64'(icache_gnt),       64'(acc && sel_ic));
            chk("m_dgnt",  64'(dcache_gnt),       64'(acc && sel_dc));
            chk("m_dbg",   64'(gnt_debug),        64'({sel_dc, sel_ic}));
            chk("m_irsp",  64'(icache_rsp_valid), 64'(hit && own == 0));
            chk("m_drsp",  64'(dcache_rsp_valid), 64'(hit && own == 1));
            chk("m_out",   64'(outstanding),      64'(owner_map.num()));
            chk("m_spur",  64'(spurious_tag),     64'(spur_m));
            if (hit) begin
                chk("m_rsp_tag",  64'(rsp_tag), 64'(v.rtag));
                chk("m_rsp_data", rsp_data,     v.rdata);
            end
        end
        @(posedge clock);
        if (hit) owner_map.delete(int'(v.rtag));
        else if (v.rtag != 0) spur_m = 1;
        m_acc_ic = acc && sel_ic;
        m_acc_dc = acc && sel_dc;
        if (acc) begin
            last_w = sel_dc ? 1 : 0;
            if (m_cmd == L) owner_map[int'(v.resp)] = sel_dc ? 1 : 0;
        end
        #1;
    endtask

    task automatic do_reset();
        icache_command = N; dcache_command = N;
        icache_addr = '0; dcache_addr = '0; dcache_data = '0;
        mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("rst_cmd",  64'(proc2mem_command), 64'(N));
        chk("rst_gnt",  64'({icache_gnt, dcache_gnt}), 64'h0);
        chk("rst_out",  64'(outstanding), 64'h0);
        chk("rst_spur", 64'(spurious_tag), 64'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    vec_t tbl [16];
    vec_t v;

    initial begin
        //          ic  ic_addr       dc  dc_addr       dc_data       rsp  rtag  rdata
        //          e_cmd e_addr      e_data        ig dg ir dr out spur
        tbl[0]  = '{L, 32'h1000, N, 32'h0,    64'h0,    4'd3, 4'd0, 64'h0,
                    L, 32'h1000, 64'h0,    1, 0, 0, 0, 4'd0, 0};
        tbl[1]  = '{N, 32'h0,    N, 32'h0,    64'h0,    4'd0, 4'd3, 64'hDEAD_BEEF_0000_1111,
                    N, 32'h0,    64'h0,    0, 0, 1, 0, 4'd1, 0};
        tbl[2]  = '{N, 32'h0,    N, 32'h0,    64'h0,    4'd0, 4'd0, 64'h0,
                    N, 32'h0,    64'h0,    0, 0, 0, 0, 4'd0, 0};
        tbl[3]  = '{L, 32'h1100, L, 32'h2200, 64'h0,    4'd1, 4'd0, 64'h0,
                    L, 32'h2200, 64'h0,    0, 1, 0, 0, 4'd0, 0};
        tbl[4]  = '{L, 32'h1100, L, 32'h2200, 64'h0,    4'd2, 4'd1, 64'hA,
                    L, 32'h1100, 64'h0,    1, 0, 0, 1, 4'd1, 0};
        tbl[5]  = '{L, 32'h1100, L, 32'h2200, 64'h0,    4'd0, 4'd2, 64'hB,
                    L, 32'h2200, 64'h0,    0, 0, 1, 0, 4'd1, 0};
        tbl[6]  = '{L, 32'h1100, L, 32'h2200, 64'h0,    4'd5, 4'd0, 64'h0,
                    L, 32'h2200, 64'h0,    0, 1, 0, 0, 4'd0, 0};
        tbl[7]  = '{L, 32'h1100, L, 32'h2200, 64'h0,    4'd6, 4'd0, 64'h0,
                    L, 32'h1100, 64'h0,    1, 0, 0, 0, 4'd1, 0};
        tbl[8]  = '{L, 32'h1100, S, 32'h2000, 64'h1234, 4'd7, 4'd0, 64'h0,
                    S, 32'h2000, 64'h1234, 0, 1, 0, 0, 4'd2, 0};
        tbl[9]  = '{L, 32'h1100, N, 32'h0,    64'h0,    4'd4, 4'd5, 64'h55,
                    N, 32'h0,    64'h0,    0, 0, 0, 1, 4'd2, 0};
        tbl[10] = '{L, 32'h1100, N, 32'h0,    64'h0,    4'd4, 4'd0, 64'h0,
                    L, 32'h1100, 64'h0,    1, 0, 0, 0, 4'd1, 0};
        tbl[11] = '{N, 32'h0,    N, 32'h0,    64'h0,    4'd0, 4'd7, 64'h77,
                    N, 32'h0,    64'h0,    0, 0, 0, 0, 4'd2, 0};
        tbl[12] = '{N, 32'h0,    N, 32'h0,    64'h0,    4'd0, 4'd6, 64'h66,
                    N, 32'h0,    64'h0,    0, 0, 1, 0, 4'd2, 1};
        tbl[13] = '{N, 32'h0,    L, 32'h3000, 64'h0,    4'd4, 4'd4, 64'hC,
                    L, 32'h3000, 64'h0,    0, 1, 1, 0, 4'd1, 1};
        tbl[14] = '{N, 32'h0,    N, 32'h0,    64'h0,    4'd0, 4'd4, 64'hD,
                    N, 32'h0,    64'h0,    0, 0, 0, 1, 4'd1, 1};
        tbl[15] = '{N, 32'h0,    N, 32'h0,    64'h0,    4'd0, 4'd0, 64'h0,
                    N, 32'h0,    64'h0,    0, 0, 0, 0, 4'd0, 1};

        do_reset();
        for (int i = 0; i < 16; i++) run_cycle(tbl[i], 1'b1);

        // Reset while a load is in flight: its late return must be spurious.
        v = tbl[15];
        v.ic_cmd = L; v.ic_addr = 32'h4000; v.resp = 4'd8;
        do_reset();
        run_cycle(v, 1'b0);
        do_reset();
        v = tbl[15]; v.rtag = 4'd8; v.rdata = 64'h88;
        run_cycle(v, 1'b0);
        v.rtag = 4'd0;
        run_cycle(v, 1'b0);

        // Randomized traffic against the ownership model.
        do_reset();
        v = tbl[15];
        m_acc_ic = 1; m_acc_dc = 1;
        for (int c = 0; c < 600; c++) begin
            int keys [$];
            int r;
            bit hit;
            if (m_acc_ic || v.ic_cmd == N || v.ic_cmd == S) begin
                v.ic_cmd  = 2'($urandom_range(0, 2));
                v.ic_addr = $urandom;
            end
            if (m_acc_dc || v.dc_cmd == N) begin
                v.dc_cmd  = 2'($urandom_range(0, 2));
                v.dc_addr = $urandom;
                v.dc_data = {$urandom, $urandom};
            end
            keys.delete();
            foreach (owner_map[k]) keys.push_back(k);
            r = int'($urandom_range(0, 99));
            if (r < 45 && keys.size() > 0)
                v.rtag = 4'(keys[$urandom_range(0, keys.size() - 1)]);
            else if (r < 48)
                v.rtag = 4'($urandom_range(1, 15));
            else
                v.rtag = 4'd0;
            v.rdata = {$urandom, $urandom};
            hit = (v.rtag != 0) && owner_map.exists(int'(v.rtag));
            v.resp = 4'd0;
            if ($urandom_range(0, 4) != 0) begin
                for (int t = 0; t < 16; t++) begin
                    r = int'($urandom_range(1, 15));
                    if (!owner_map.exists(r) || (hit && r == int'(v.rtag))) begin
                        v.resp = 4'(r);
                        break;
                    end
                end
            end
            run_cycle(v, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory bus (proc2mem_*/mem2proc_*) between the instruction-cache fetch path and the data-cache path.
- Selects one requester per cycle using round-robin priority and drives its command onto the bus.
- Records which requester owns each accepted tag, then routes tagged load data back to that owner.
- Sits between icache/dcache and the memory model, under ifetch.

Parameters:
- MAX_OUTSTANDING, 8: maximum in-flight loads. Range 1..15.
- TAG_W, 4: width of memory tags. Tag 0 means none/reject.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- icache_command  in  2  BUS_NONE/BUS_LOAD only; BUS_STORE is treated as BUS_NONE.
- icache_addr  in  XLEN  icache request address.
- dcache_command  in  2  BUS_NONE/BUS_LOAD/BUS_STORE.
- dcache_addr  in  XLEN  dcache request address.
- dcache_data  in  64  dcache store data.
- icache_gnt  out  1  icache request accepted this cycle.
- dcache_gnt  out  1  dcache request accepted this cycle.
- gnt_tag  out  TAG_W  tag of the accepted transaction (equals mem2proc_response).
- proc2mem_command  out  2  bus command.
- proc2mem_addr  out  XLEN  bus address.
- proc2mem_data  out  64  bus store data.
- mem2proc_response  in  TAG_W  accept tag; 0 means reject.
- mem2proc_data  in  64  returned load data.
- mem2proc_tag  in  TAG_W  tag of returned data; 0 means none.
- icache_rsp_valid  out  1  load data for icache.
- dcache_rsp_valid  out  1  load data for dcache.
- rsp_tag  out  TAG_W  tag of routed data.
- rsp_data  out  64  routed data (mem2proc_data).
- outstanding  out  4  in-flight load count.
- spurious_tag  out  1  sticky: data returned with a tag not owned.
- gnt_debug  out  2  {dcache_sel, icache_sel} this cycle.

Behaviour:
- Reset (reset==0 at posedge):
  - Tag table cleared (all valid=0).
  - outstanding=0.
  - last_winner=DCACHE, so icache wins the first tie.
  - spurious_tag=0.
  - Combinational outputs follow from the cleared state.
- Selection is combinational, same cycle.
  - Candidates: requesters with a non-NONE command.
  - If both are candidates, the one not equal to last_winner is selected.
  - Loads are not candidates when outstanding==MAX_OUTSTANDING. Stores are unaffected.
  - Selected request is driven onto proc2mem_*. With no selection, proc2mem_command=BUS_NONE and addr/data=0.
- Handshake:
  - Requesters hold command/addr/data stable until they see their gnt.
  - gnt = selected AND mem2proc_response!=0, in the same cycle. gnt_tag=mem2proc_response.
  - A rejected request (response 0) leaves last_winner unchanged and is retried next cycle.
- On an accepted load, at posedge:
  - table[tag] <= {valid=1, owner}.
  - outstanding increments.
  - last_winner <= owner.
- Accepted stores update last_winner only. They allocate no entry and expect no data.
- Return:
  - When mem2proc_tag!=0 and table[tag].valid, assert the owner's rsp_valid combinationally in the same cycle, with rsp_tag and rsp_data.
  - At posedge, clear the entry and decrement outstanding.
- Return with tag!=0 and no valid entry: no rsp_valid, and spurious_tag sets. It clears only on reset.
- Simultaneous accept and return in one cycle: outstanding is unchanged.
  - If the returned tag equals the newly accepted tag, the allocation wins and the entry stays valid with the new owner.
- Counter width: outstanding never exceeds MAX_OUTSTANDING and never goes below 0. A decrement at 0 cannot occur, because a return requires a valid entry.
- Reset mid-operation: all entries are abandoned. Late returns for pre-reset tags are treated as spurious (dropped, flag set).

Test Plan:
- Reset then idle:
  - Hold reset=0 for 2 cycles, then 1.
  - Expect proc2mem_command=BUS_NONE, all gnt=0, outstanding=0, spurious_tag=0.
- Single icache load:
  - icache_command=LOAD, addr=32'h0000_1000, response=3.
  - Expect icache_gnt=1 and gnt_tag=3 that cycle, then outstanding=1.
  - Later mem2proc_tag=3, data=64'hDEAD_BEEF_0000_1111: icache_rsp_valid=1, dcache_rsp_valid=0, outstanding returns to 0.
- Round-robin contention:
  - Both requesters load continuously, response always nonzero.
  - Expect grants in the order icache, dcache, icache, dcache.
  - A reject (response=0) in cycle 2 repeats the dcache selection in cycle 3.
- Store passthrough:
  - dcache STORE addr=32'h2000, data=64'h1234, response=5.
  - Expect proc2mem_data=64'h1234, dcache_gnt=1, outstanding unchanged.
  - A later mem2proc_tag=5 sets spurious_tag=1.
- Outstanding limit with MAX_OUTSTANDING=2:
  - Two icache loads are accepted (tags 1, 2).
  - A third icache load gives proc2mem_command=NONE, while a concurrent dcache store is still granted.
  - Returning tag 1 frees the slot and the load is granted the next cycle.
- Simultaneous return, accept and tag reuse:
  - Tag 4 outstanding for icache; the same cycle returns tag 4 and accepts a dcache load with response 4.
  - Expect icache_rsp_valid=1, outstanding unchanged, and table[4] owner=dcache (a subsequent tag-4 return goes to dcache).
